// File: rtl/tx_fire_sequencer.sv
// Transmit firing sequencer. Each rising edge of div_clk starts one transmit
// event. In that event every channel emits one PULSE_LEN-cycle pulse after
// its own latched delay.
//
// state   | meaning
// --------+-----------------------------------------------------------
// ST_IDLE | waiting for an enabled div_clk rising edge; tx_pulse low
// ST_FIRE | event in progress; elapsed counts cycles since the trigger
module tx_fire_sequencer #(
    parameter int NUM_CH    = 4,
    parameter int DELAY_W   = 8,
    parameter int PULSE_LEN = 4
) (
    input  logic                        clock,
    input  logic                        reset_n,
    input  logic                        div_clk,
    input  logic                        enable,
    input  logic [NUM_CH*DELAY_W-1:0]   delays,
    output logic [NUM_CH-1:0]           tx_pulse,
    output logic                        busy,
    output logic [15:0]                 fire_count,
    output logic                        overrun
);

    // One extra bit so max(delay) + PULSE_LEN never overflows.
    localparam int CNT_W = DELAY_W + 1;
    localparam logic [CNT_W-1:0] PULSE_LEN_C = CNT_W'(PULSE_LEN);
    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_FIRE = 1'b1
    } state_t;

    state_t                           state_q, state_d;
    logic                             div_clk_q, div_clk_d;
    logic [NUM_CH-1:0][DELAY_W-1:0]   d_q, d_d;
    logic [CNT_W-1:0]                 end_cnt_q, end_cnt_d;
    logic [CNT_W-1:0]                 elapsed_q, elapsed_d;
    logic [15:0]                      fire_count_q, fire_count_d;
    logic [NUM_CH-1:0]                tx_pulse_q, tx_pulse_d;
    logic                             overrun_q, overrun_d;
    logic                             trig;
    logic [DELAY_W-1:0]               max_in;

    // div_clk is treated as data: a rising edge is the trigger.
    assign div_clk_d = div_clk;
    assign trig      = div_clk & ~div_clk_q;

    // Largest incoming delay, used to size the event at trigger time.
    always_comb begin
        max_in = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (delays[i*DELAY_W +: DELAY_W] > max_in) begin
                max_in = delays[i*DELAY_W +: DELAY_W];
            end
        end
    end

    // Next-state, event timing and per-channel pulse window decode.
    always_comb begin
        state_d      = state_q;
        d_d          = d_q;
        end_cnt_d    = end_cnt_q;
        elapsed_d    = elapsed_q;
        fire_count_d = fire_count_q;
        tx_pulse_d   = '0;
        overrun_d    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (trig && enable) begin
                    state_d      = ST_FIRE;
                    d_d          = delays;
                    end_cnt_d    = {1'b0, max_in} + PULSE_LEN_C;
                    elapsed_d    = '0;
                    fire_count_d = fire_count_q + 16'd1;
                end
            end
            ST_FIRE: begin
                for (int i = 0; i < NUM_CH; i++) begin
                    tx_pulse_d[i] = (elapsed_q >= {1'b0, d_q[i]}) &&
                                    (elapsed_q < ({1'b0, d_q[i]} + PULSE_LEN_C));
                end
                elapsed_d = elapsed_q + CNT_ONE;
                // A trigger during an event is dropped and only flagged.
                overrun_d = trig;
                if (elapsed_q == end_cnt_q) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers; div_clk_q resets high so a div_clk
    // already high at reset release does not fire.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ST_IDLE;
            div_clk_q    <= 1'b1;
            d_q          <= '0;
            end_cnt_q    <= '0;
            elapsed_q    <= '0;
            fire_count_q <= '0;
            tx_pulse_q   <= '0;
            overrun_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            div_clk_q    <= div_clk_d;
            d_q          <= d_d;
            end_cnt_q    <= end_cnt_d;
            elapsed_q    <= elapsed_d;
            fire_count_q <= fire_count_d;
            tx_pulse_q   <= tx_pulse_d;
            overrun_q    <= overrun_d;
        end
    end

    assign tx_pulse   = tx_pulse_q;
    assign busy       = (state_q == ST_FIRE);
    assign fire_count = fire_count_q;
    assign overrun    = overrun_q;

endmodule

// File: tb/tb_tx_fire_sequencer.sv
// Bench for tx_fire_sequencer. The reference model works in absolute cycle
// numbers: an accepted trigger at cycle t0 with delays d_i means channel i is
// high for cycles t0+d_i+1 .. t0+d_i+PL and busy lasts through t0+max+PL.
module tb_tx_fire_sequencer;

    localparam int NCH = 4;
    localparam int DW  = 8;
    localparam int PL  = 4;

    logic              clock;
    logic              reset_n;
    logic              div_clk;
    logic              enable;
    logic [NCH*DW-1:0] delays;
    logic [NCH-1:0]    tx_pulse;
    logic              busy;
    logic [15:0]       fire_count;
    logic              overrun;

    tx_fire_sequencer #(
        .NUM_CH    (NCH),
        .DELAY_W   (DW),
        .PULSE_LEN (PL)
    ) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .div_clk    (div_clk),
        .enable     (enable),
        .delays     (delays),
        .tx_pulse   (tx_pulse),
        .busy       (busy),
        .fire_count (fire_count),
        .overrun    (overrun)
    );

    initial clock = 1'b0;
    always #4 clock = ~clock;

    int          errors = 0;
    int          checks = 0;
    int          cyc    = 0;
    logic        m_prev = 1'b1;
    logic        m_active = 1'b0;
    logic        m_over = 1'b0;
    int          m_t0 = 0;
    int          m_d [NCH];
    int          m_max = 0;
    logic [15:0] m_cnt = 16'd0;

    task automatic check_outputs();
        logic [NCH-1:0] exp_tx;
        int k;
        k = cyc - m_t0;
        exp_tx = '0;
        for (int i = 0; i < NCH; i++) begin
            exp_tx[i] = m_active && (k >= m_d[i] + 1) && (k <= m_d[i] + PL);
        end
        checks++;
        assert (tx_pulse === exp_tx) else begin
            errors++;
            $error("FAIL tx_pulse cyc=%0d got=%b exp=%b", cyc, tx_pulse, exp_tx);
        end
        checks++;
        assert (busy === m_active) else begin
            errors++;
            $error("FAIL busy cyc=%0d got=%b exp=%b", cyc, busy, m_active);
        end
        checks++;
        assert (fire_count === m_cnt) else begin
            errors++;
            $error("FAIL fire_count cyc=%0d got=%0d exp=%0d", cyc, fire_count, m_cnt);
        end
        checks++;
        assert (overrun === m_over) else begin
            errors++;
            $error("FAIL overrun cyc=%0d got=%b exp=%b", cyc, overrun, m_over);
        end
    endtask

    // One clock edge: advance the model with the inputs seen at the edge,
    // then compare just after the edge.
    task automatic tick();
        logic trig;
        @(posedge clock);
        cyc++;
        if (!reset_n) begin
            m_prev   = 1'b1;
            m_active = 1'b0;
            m_over   = 1'b0;
            m_cnt    = 16'd0;
        end else begin
            trig   = div_clk && !m_prev;
            m_prev = div_clk;
            m_over = trig && m_active;
            if (m_active) begin
                if (cyc - m_t0 > m_max + PL) m_active = 1'b0;
            end else if (trig && enable) begin
                m_t0  = cyc;
                m_max = 0;
                for (int i = 0; i < NCH; i++) begin
                    m_d[i] = int'(delays[i*DW +: DW]);
                    if (m_d[i] > m_max) m_max = m_d[i];
                end
                m_cnt    = m_cnt + 16'd1;
                m_active = 1'b1;
            end
        end
        #1;
        check_outputs();
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    // Rising div_clk sampled at the next edge (E0), then dropped again.
    task automatic pulse_div();
        div_clk = 1'b1;
        tick();
        div_clk = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < NCH; i++) m_d[i] = 0;
        reset_n = 1'b0;
        div_clk = 1'b0;
        enable  = 1'b1;
        delays  = '0;
        #1;
        check_outputs();
        run(2);
        reset_n = 1'b1;
        run(3);

        // Basic fire: ch0=0, ch1=3, ch2=7, ch3=1
        delays = {8'd1, 8'd7, 8'd3, 8'd0};
        pulse_div();
        run(11);
        checks++;
        assert (busy === 1'b1) else begin
            errors++;
            $error("FAIL basic_busy_E11 got=%b exp=1", busy);
        end
        tick();
        checks++;
        assert (busy === 1'b0 && fire_count === 16'd1) else begin
            errors++;
            $error("FAIL basic_end_E12 busy=%b count=%0d exp busy=0 count=1", busy, fire_count);
        end
        run(3);

        // Maximum delay on ch0
        delays = {8'd0, 8'd0, 8'd0, 8'd255};
        pulse_div();
        run(262);

        // Overrun at E5 of an event with max delay 7
        delays = {8'd7, 8'd2, 8'd5, 8'd0};
        pulse_div();
        run(4);
        div_clk = 1'b1;
        tick();
        div_clk = 1'b0;
        run(12);
        pulse_div();
        run(14);

        // Enable gating, enable drop mid-event, delays change mid-event
        enable = 1'b0;
        pulse_div();
        run(6);
        enable = 1'b1;
        delays = {8'd4, 8'd0, 8'd9, 8'd2};
        pulse_div();
        run(2);
        enable = 1'b0;
        delays = {8'd0, 8'd30, 8'd1, 8'd17};
        run(16);
        enable = 1'b1;

        // Randomised events with random spacing (some overrun, some gated)
        for (int e = 0; e < 25; e++) begin
            for (int i = 0; i < NCH; i++) begin
                delays[i*DW +: DW] = DW'($urandom_range(0, 20));
            end
            enable = ($urandom_range(0, 7) != 0);
            pulse_div();
            run($urandom_range(3, 30));
        end
        enable = 1'b1;
        run(30);

        // Reset mid-event at E3, released with div_clk high
        delays = {8'd4, 8'd9, 8'd5, 8'd2};
        pulse_div();
        run(3);
        #2;
        reset_n = 1'b0;
        div_clk = 1'b1;
        #1;
        m_active = 1'b0;
        m_over   = 1'b0;
        m_cnt    = 16'd0;
        m_prev   = 1'b1;
        checks++;
        assert (tx_pulse === '0 && busy === 1'b0 && fire_count === 16'd0 && overrun === 1'b0) else begin
            errors++;
            $error("FAIL async_reset tx=%b busy=%b count=%0d ovr=%b exp all zero",
                   tx_pulse, busy, fire_count, overrun);
        end
        run(2);
        reset_n = 1'b1;
        run(5);
        div_clk = 1'b0;
        tick();
        pulse_div();
        run(14);

        // Counter wrap from 16'hFFFF
        delays = '0;
        force dut.fire_count_q = 16'hFFFF;
        m_cnt = 16'hFFFF;
        tick();
        release dut.fire_count_q;
        run(2);
        pulse_div();
        checks++;
        assert (fire_count === 16'h0000) else begin
            errors++;
            $error("FAIL count_wrap got=%0h exp=0", fire_count);
        end
        run(8);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
